pwm_led_bz: RTL and testbench

PWM_LED_BZ -- requirements
Module: pwm_led_bz

---
 rtl/pwm_led_bz_if.sv | 40 ++++
 rtl/pwm_led_bz.sv | 154 +++++++++++++++
 tb/tb_pwm_led_bz.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pwm_led_bz_if.sv
// ----------------------------------------------------------------------------
// pwm_led_bz_if
// Register/output bundle for the PWM LED/buzzer driver. Clock and reset stay
// plain ports on the design; this interface carries everything else.
//
//   FREQ_Cnt_Reg   [31:0]  PWM period P in clock cycles
//   BZ_Puty_Reg    [31:0]  buzzer high-time
//   LEDR_Puty_Reg  [31:0]  red LED high-time
//   LEDG_Puty_Reg  [31:0]  green LED high-time
//   LEDB_Puty_Reg  [31:0]  blue LED high-time
//   BZ_PWM, LEDR_PWM, LEDG_PWM, LEDB_PWM   channel drives
//   PERIOD_END     one-cycle pulse at the start of each period
//   RUNNING        high while the generator is running
//
// master: register-file side (drives setup, observes drives)
// slave : the PWM block itself
// ----------------------------------------------------------------------------
interface pwm_led_bz_if;
    logic [31:0] FREQ_Cnt_Reg;
    logic [31:0] BZ_Puty_Reg;
    logic [31:0] LEDR_Puty_Reg;
    logic [31:0] LEDG_Puty_Reg;
    logic [31:0] LEDB_Puty_Reg;
    logic        BZ_PWM;
    logic        LEDR_PWM;
    logic        LEDG_PWM;
    logic        LEDB_PWM;
    logic        PERIOD_END;
    logic        RUNNING;

    modport master (
        output FREQ_Cnt_Reg, BZ_Puty_Reg, LEDR_Puty_Reg, LEDG_Puty_Reg, LEDB_Puty_Reg,
        input  BZ_PWM, LEDR_PWM, LEDG_PWM, LEDB_PWM, PERIOD_END, RUNNING
    );

    modport slave (
        input  FREQ_Cnt_Reg, BZ_Puty_Reg, LEDR_Puty_Reg, LEDG_Puty_Reg, LEDB_Puty_Reg,
        output BZ_PWM, LEDR_PWM, LEDG_PWM, LEDB_PWM, PERIOD_END, RUNNING
    );
endinterface

// File: rtl/pwm_led_bz.sv
// ----------------------------------------------------------------------------
// pwm_led_bz
// Four-channel PWM generator (buzzer + RGB LED) sharing one period counter.
// Period and duty values are captured into shadow registers at each period
// boundary, so register writes mid-period never produce a partial period.
//
// Ports:
//   CLK   clock, everything on the rising edge
//   RST   synchronous active-high reset
//   bus   pwm_led_bz_if.slave: period/duty inputs, PWM drives, PERIOD_END,
//         RUNNING
//
// Parameter:
//   LED_ACTIVE_LOW  1 = the three LED drives are inverted (buzzer never is)
// ----------------------------------------------------------------------------
module pwm_led_bz #(
    parameter bit LED_ACTIVE_LOW = 1'b0
) (
    input  logic         CLK,
    input  logic         RST,
    pwm_led_bz_if.slave  bus
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Channel order inside the packed vectors: 0 = buzzer, 1 = R, 2 = G, 3 = B.
    localparam int NCH = 4;

    // Inactive level of each drive; XOR-ing with it maps "active" onto the pin.
    localparam logic [NCH-1:0] POL_MASK = {{3{LED_ACTIVE_LOW}}, 1'b0};

    state_t                 state_q, state_d;
    logic [31:0]            cnt_q, cnt_d;
    logic [31:0]            p_sh_q, p_sh_d;
    logic [NCH-1:0][31:0]   d_sh_q, d_sh_d;
    logic [NCH-1:0]         out_q, out_d;
    logic                   period_end_q, period_end_d;
    logic                   running_q;

    logic [NCH-1:0][31:0]   d_in;
    logic                   freq_ok;
    logic                   at_end;
    logic                   load;

    assign d_in[0] = bus.BZ_Puty_Reg;
    assign d_in[1] = bus.LEDR_Puty_Reg;
    assign d_in[2] = bus.LEDG_Puty_Reg;
    assign d_in[3] = bus.LEDB_Puty_Reg;

    // Periods of 0 or 1 cycle are not runnable; the generator parks in IDLE.
    assign freq_ok = (bus.FREQ_Cnt_Reg >= 32'd2);

    // p_sh_q is always >= 2 while in RUN, so the subtraction cannot wrap there.
    assign at_end  = (cnt_q == p_sh_q - 32'd1);

    // ------------------------------------------------------------------------
    // Next-state / counter / shadow-load logic
    // ------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        p_sh_d       = p_sh_q;
        d_sh_d       = d_sh_q;
        period_end_d = 1'b0;
        load         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (freq_ok) begin
                    load         = 1'b1;
                    state_d      = ST_RUN;
                    period_end_d = 1'b1;
                end
            end

            ST_RUN: begin
                if (!at_end) begin
                    cnt_d = cnt_q + 32'd1;
                end else begin
                    cnt_d = '0;
                    if (freq_ok) begin
                        load         = 1'b1;
                        period_end_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (load) begin
            p_sh_d = bus.FREQ_Cnt_Reg;
            d_sh_d = d_in;
        end
    end

    // ------------------------------------------------------------------------
    // Channel compare: active while running and still inside the high-time.
    // D_sh >= P_sh keeps the compare true across the whole period, including
    // the wrap cycle, and D_sh = 0 never matches.
    // ------------------------------------------------------------------------
    always_comb begin
        out_d = POL_MASK;
        for (int i = 0; i < NCH; i++) begin
            out_d[i] = ((state_q == ST_RUN) && (cnt_q < d_sh_q[i])) ^ POL_MASK[i];
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            // Shadows are a handful of flops, not a memory, so they are
            // cleared with the rest of the state.
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            p_sh_q       <= '0;
            d_sh_q       <= '0;
            out_q        <= POL_MASK;
            period_end_q <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            p_sh_q       <= p_sh_d;
            d_sh_q       <= d_sh_d;
            out_q        <= out_d;
            period_end_q <= period_end_d;
            running_q    <= (state_q == ST_RUN);
        end
    end

    assign bus.BZ_PWM     = out_q[0];
    assign bus.LEDR_PWM   = out_q[1];
    assign bus.LEDG_PWM   = out_q[2];
    assign bus.LEDB_PWM   = out_q[3];
    assign bus.PERIOD_END = period_end_q;
    assign bus.RUNNING    = running_q;

endmodule

// File: tb/tb_pwm_led_bz.sv
// ----------------------------------------------------------------------------
// tb_pwm_led_bz
// Directed bench for pwm_led_bz. dut0 uses active-high LEDs, dut1 active-low.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_pwm_led_bz;

    logic CLK  = 1'b0;
    logic RST0 = 1'b1;
    logic RST1 = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    pwm_led_bz_if if0 ();
    pwm_led_bz_if if1 ();

    pwm_led_bz #(.LED_ACTIVE_LOW(1'b0)) dut0 (.CLK(CLK), .RST(RST0), .bus(if0.slave));
    pwm_led_bz #(.LED_ACTIVE_LOW(1'b1)) dut1 (.CLK(CLK), .RST(RST1), .bus(if1.slave));

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Compares all six dut0 outputs against expected values.
    task automatic check0(input string tag, input bit bz, input bit r, input bit g,
                          input bit b, input bit pe, input bit run);
        check({tag, " bz"},  32'(if0.BZ_PWM),     32'(bz));
        check({tag, " r"},   32'(if0.LEDR_PWM),   32'(r));
        check({tag, " g"},   32'(if0.LEDG_PWM),   32'(g));
        check({tag, " b"},   32'(if0.LEDB_PWM),   32'(b));
        check({tag, " pe"},  32'(if0.PERIOD_END), 32'(pe));
        check({tag, " run"}, 32'(if0.RUNNING),    32'(run));
    endtask

    task automatic check1(input string tag, input bit bz, input bit r, input bit g,
                          input bit b, input bit pe, input bit run);
        check({tag, " bz"},  32'(if1.BZ_PWM),     32'(bz));
        check({tag, " r"},   32'(if1.LEDR_PWM),   32'(r));
        check({tag, " g"},   32'(if1.LEDG_PWM),   32'(g));
        check({tag, " b"},   32'(if1.LEDB_PWM),   32'(b));
        check({tag, " pe"},  32'(if1.PERIOD_END), 32'(pe));
        check({tag, " run"}, 32'(if1.RUNNING),    32'(run));
    endtask

    initial begin
        bit exp_bz, exp_gb, exp_pe, exp_run, act;
        int c;

        if0.FREQ_Cnt_Reg  = '0;
        if0.BZ_Puty_Reg   = '0;
        if0.LEDR_Puty_Reg = '0;
        if0.LEDG_Puty_Reg = '0;
        if0.LEDB_Puty_Reg = '0;
        if1.FREQ_Cnt_Reg  = '0;
        if1.BZ_Puty_Reg   = '0;
        if1.LEDR_Puty_Reg = '0;
        if1.LEDG_Puty_Reg = '0;
        if1.LEDB_Puty_Reg = '0;

        // ---- reset values ---------------------------------------------------
        tick();
        tick();
        check0("rst0", 0, 0, 0, 0, 0, 0);
        check1("rst1", 0, 1, 1, 1, 0, 0);

        // ---- scenarios 1-4 on dut0: P=10, BZ=3, R=0, G=10, B=max -------------
        if0.FREQ_Cnt_Reg  = 32'd10;
        if0.BZ_Puty_Reg   = 32'd3;
        if0.LEDR_Puty_Reg = 32'd0;
        if0.LEDG_Puty_Reg = 32'd10;
        if0.LEDB_Puty_Reg = 32'hFFFF_FFFF;
        RST0 = 1'b0;
        tick();
        // First PERIOD_END; outputs lag the counter by one cycle.
        check0("start", 0, 0, 0, 0, 1, 0);

        // Periods end at k=10,20,30,40. BZ becomes 6 while CNT=4 of the third
        // period (takes effect from k=31). P becomes 1 while CNT=4 of the
        // fourth period, so the block idles after k=50 with no pulse there.
        for (int k = 1; k <= 60; k++) begin
            tick();
            c = (k - 1) % 10;
            if (k <= 50) begin
                exp_bz  = (k <= 30) ? (c < 3) : (c < 6);
                exp_gb  = 1'b1;
                exp_run = 1'b1;
            end else begin
                exp_bz  = 1'b0;
                exp_gb  = 1'b0;
                exp_run = 1'b0;
            end
            exp_pe = ((k % 10) == 0) && (k <= 40);
            check0($sformatf("s1 k=%0d", k), exp_bz, 0, exp_gb, exp_gb, exp_pe, exp_run);
            if (k == 24) if0.BZ_Puty_Reg = 32'd6;
            if (k == 44) if0.FREQ_Cnt_Reg = 32'd1;
        end

        // ---- scenario 5: reset at CNT=5, restart with P=8 --------------------
        if0.FREQ_Cnt_Reg = 32'd10;
        tick();
        check("s5 restart pe", 32'(if0.PERIOD_END), 32'd1);
        repeat (5) tick();
        RST0 = 1'b1;
        if0.FREQ_Cnt_Reg = 32'd8;
        tick();
        check0("s5 rst", 0, 0, 0, 0, 0, 0);
        RST0 = 1'b0;
        tick();
        check0("s5 rel", 0, 0, 0, 0, 1, 0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            c = (k - 1) % 8;
            check0($sformatf("s5 k=%0d", k), (c < 6), 0, 1, 1, ((k % 8) == 0), 1);
        end

        // ---- reset wins over a period boundary (CNT=7=P-1) -------------------
        repeat (7) tick();
        RST0 = 1'b1;
        tick();
        check0("rst@end", 0, 0, 0, 0, 0, 0);
        RST0 = 1'b0;
        if0.FREQ_Cnt_Reg = 32'd1;
        tick();
        tick();
        check0("idle p=1", 0, 0, 0, 0, 0, 0);

        // ---- scenario 6 on dut1: active-low LEDs, P=4, all D=1 ---------------
        if1.FREQ_Cnt_Reg  = 32'd4;
        if1.BZ_Puty_Reg   = 32'd1;
        if1.LEDR_Puty_Reg = 32'd1;
        if1.LEDG_Puty_Reg = 32'd1;
        if1.LEDB_Puty_Reg = 32'd1;
        RST1 = 1'b0;
        tick();
        check1("s6 start", 0, 1, 1, 1, 1, 0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            act = (((k - 1) % 4) == 0);
            check1($sformatf("s6 k=%0d", k), act, !act, !act, !act, ((k % 4) == 0), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
